// File: rtl/rd_line_dma_pkg.sv
// Shared types and constants for the line-read DMA: FSM state encoding,
// MCB instruction codes and the internal index widths.
package rd_line_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CMD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_NEXT  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        MCB_WRITE = 3'b000,
        MCB_READ  = 3'b001
    } mcb_instr_e;

    // Index widths sized for the largest legal parameter values.
    localparam int LINE_W  = 16;
    localparam int CH_W    = 2;
    localparam int BURST_W = 8;
    localparam int WCNT_W  = 7;

endpackage

// File: rtl/rd_line_dma_if.sv
// MCB command/read port plus downstream FIFO write port of the line-read DMA.
interface rd_line_dma_if #(
    parameter int DWIDTH = 128
);
    logic              mcb_cmd_en;
    logic [2:0]        mcb_cmd_instr;
    logic [5:0]        mcb_cmd_bl;
    logic [29:0]       mcb_cmd_byte_addr;
    logic              mcb_cmd_full;
    logic              mcb_rd_en;
    logic [DWIDTH-1:0] mcb_rd_data;
    logic              mcb_rd_empty;
    logic [6:0]        mcb_rd_count;
    logic              fifo_wr_en;
    logic [DWIDTH-1:0] fifo_wr_data;
    logic              fifo_full;

    modport master (
        output mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
        input  mcb_cmd_full,
        output mcb_rd_en,
        input  mcb_rd_data, mcb_rd_empty, mcb_rd_count,
        output fifo_wr_en, fifo_wr_data,
        input  fifo_full
    );

    modport slave (
        input  mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
        output mcb_cmd_full,
        input  mcb_rd_en,
        output mcb_rd_data, mcb_rd_empty, mcb_rd_count,
        input  fifo_wr_en, fifo_wr_data,
        output fifo_full
    );

endinterface

// File: rtl/rd_line_dma_addr_gen.sv
// Combinational MCB byte-address generator for one burst of a line fetch.
module rd_line_addr_gen
    import rd_line_dma_pkg::*;
#(
    parameter int DWIDTH            = 128,
    parameter int BRST_LEN          = 45,
    parameter int CH_STRIDE_BYTE    = 1440,
    parameter int HSTART_BYTE       = 0,
    parameter int LINE_STRIDE_BYTE  = 4096,
    parameter int FRAME_OFFSET_BYTE = 4194304
) (
    input  logic               frame,
    input  logic [LINE_W-1:0]  line,
    input  logic [CH_W-1:0]    ch_idx,
    input  logic [BURST_W-1:0] burst_idx,
    output logic [29:0]        addr
);
    localparam int BURST_BYTES = BRST_LEN * (DWIDTH / 8);

    logic [29:0] frame_term_s;
    logic [29:0] line_term_s;
    logic [29:0] ch_term_s;
    logic [29:0] burst_term_s;

    // Every term is reduced modulo 2^30 so the sum wraps like the full-width address.
    assign frame_term_s = frame ? 30'(FRAME_OFFSET_BYTE) : 30'd0;
    assign line_term_s  = 30'(64'(line) * 64'(LINE_STRIDE_BYTE));
    assign ch_term_s    = 30'(64'(ch_idx) * 64'(CH_STRIDE_BYTE));
    assign burst_term_s = 30'(64'(burst_idx) * 64'(BURST_BYTES));

    assign addr = frame_term_s + line_term_s + 30'(HSTART_BYTE) + ch_term_s + burst_term_s;

endmodule

// File: rtl/rd_line_dma.sv
// Line-read DMA: fetches NCH x BRST_NUM bursts of one video line from the MCB
// into a downstream FIFO. Define RD_LINE_DMA_ARB_EN to gate commands on arb_idle.
module rd_line_dma
    import rd_line_dma_pkg::*;
#(
    parameter int DWIDTH            = 128,
    parameter int BRST_LEN          = 45,
    parameter int BRST_NUM          = 2,
    parameter int NCH               = 2,
    parameter int CH_STRIDE_BYTE    = 1440,
    parameter int HSTART_BYTE       = 0,
    parameter int VSTART            = 0,
    parameter int LINE_DEPTH        = 900,
    parameter int LINE_STRIDE_BYTE  = 4096,
    parameter int FRAME_OFFSET_BYTE = 4194304,
    parameter int RD_THRESH         = 8
) (
    input  logic          memclk,
    input  logic          mem_rst,
    input  logic          start,
    input  logic          vs_clr,
    input  logic          frame_sel,
    input  logic          arb_idle,
    output logic          done,
    output logic          busy,
    rd_line_dma_if.master bus
);
    state_e             state_r;
    logic               frame_r;
    logic [LINE_W-1:0]  line_r;
    logic [CH_W-1:0]    ch_r;
    logic [BURST_W-1:0] burst_r;
    logic [WCNT_W-1:0]  wcnt_r;
    logic               vs_pend_r;
    logic               done_r;
    logic               busy_r;
    logic               cmd_en_r;
    logic [2:0]         cmd_instr_r;
    logic [5:0]         cmd_bl_r;
    logic [29:0]        cmd_addr_r;

    logic [29:0]        addr_s;
    logic               grant_s;
    logic               accept_s;
    logic               data_ready_s;

`ifdef RD_LINE_DMA_ARB_EN
    assign grant_s = arb_idle;
`else
    logic arb_unused_s;
    assign arb_unused_s = arb_idle;
    assign grant_s      = 1'b1;
`endif

    rd_line_addr_gen #(
        .DWIDTH            (DWIDTH),
        .BRST_LEN          (BRST_LEN),
        .CH_STRIDE_BYTE    (CH_STRIDE_BYTE),
        .HSTART_BYTE       (HSTART_BYTE),
        .LINE_STRIDE_BYTE  (LINE_STRIDE_BYTE),
        .FRAME_OFFSET_BYTE (FRAME_OFFSET_BYTE)
    ) u_addr_gen (
        .frame     (frame_r),
        .line      (line_r),
        .ch_idx    (ch_r),
        .burst_idx (burst_r),
        .addr      (addr_s)
    );

    // Word transfer strobe: one MCB pop per FIFO push, only while draining.
    always_comb begin
        accept_s = 1'b0;
        if (state_r == ST_DATA) begin
            accept_s = ~bus.mcb_rd_empty & ~bus.fifo_full;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign data_ready_s      = ~bus.mcb_rd_empty && (32'(bus.mcb_rd_count) >= 32'(RD_THRESH));
    assign bus.mcb_rd_en     = accept_s;
    assign bus.fifo_wr_en    = accept_s;
    assign bus.fifo_wr_data  = bus.mcb_rd_data;
    assign bus.mcb_cmd_en    = cmd_en_r;
    assign bus.mcb_cmd_instr = cmd_instr_r;
    assign bus.mcb_cmd_bl    = cmd_bl_r;
    assign bus.mcb_cmd_byte_addr = cmd_addr_r;
    assign done              = done_r;
    assign busy              = busy_r;

    // Line-fetch FSM with burst/channel/line bookkeeping and registered outputs.
    always_ff @(posedge memclk) begin
        if (mem_rst) begin
            state_r     <= ST_IDLE;
            frame_r     <= 1'b0;
            line_r      <= LINE_W'(VSTART);
            ch_r        <= {CH_W{1'b0}};
            burst_r     <= {BURST_W{1'b0}};
            wcnt_r      <= {WCNT_W{1'b0}};
            vs_pend_r   <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cmd_en_r    <= 1'b0;
            cmd_instr_r <= 3'b000;
            cmd_bl_r    <= 6'd0;
            cmd_addr_r  <= 30'd0;
        end else begin
            cmd_en_r <= 1'b0;
            done_r   <= 1'b0;
            // A vsync seen mid-line is deferred to the line-completion update.
            if (vs_clr && (state_r != ST_IDLE)) begin
                vs_pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (vs_clr) begin
                        line_r    <= LINE_W'(VSTART);
                        vs_pend_r <= 1'b0;
                    end
                    if (start && !done_r) begin
                        state_r <= ST_ISSUE;
                        busy_r  <= 1'b1;
                        frame_r <= frame_sel;
                        ch_r    <= {CH_W{1'b0}};
                        burst_r <= {BURST_W{1'b0}};
                        wcnt_r  <= {WCNT_W{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    if (!bus.mcb_cmd_full && grant_s) begin
                        cmd_en_r    <= 1'b1;
                        cmd_instr_r <= MCB_READ;
                        cmd_bl_r    <= 6'(BRST_LEN - 1);
                        cmd_addr_r  <= addr_s;
                        state_r     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (data_ready_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        if (wcnt_r == WCNT_W'(BRST_LEN - 1)) begin
                            wcnt_r  <= {WCNT_W{1'b0}};
                            state_r <= ST_NEXT;
                        end else begin
                            wcnt_r <= wcnt_r + WCNT_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (burst_r == BURST_W'(BRST_NUM - 1)) begin
                        burst_r <= {BURST_W{1'b0}};
                        if (ch_r == CH_W'(NCH - 1)) begin
                            ch_r      <= {CH_W{1'b0}};
                            done_r    <= 1'b1;
                            busy_r    <= 1'b0;
                            vs_pend_r <= 1'b0;
                            state_r   <= ST_IDLE;
                            if (vs_pend_r || vs_clr) begin
                                line_r <= LINE_W'(VSTART);
                            end else if (line_r == LINE_W'(VSTART + LINE_DEPTH - 1)) begin
                                line_r <= LINE_W'(VSTART);
                            end else begin
                                line_r <= line_r + LINE_W'(1);
                            end
                        end else begin
                            ch_r    <= ch_r + CH_W'(1);
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        burst_r <= burst_r + BURST_W'(1);
                        state_r <= ST_ISSUE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_line_dma.sv
// Bench for rd_line_dma: behavioural MCB model, address/data scoreboards,
// a table of line fetches and hand-written reset / vsync / wrap sequences.
module tb_rd_line_dma;
    localparam int DW  = 128;
    localparam int BL  = 45;
    localparam int BN  = 2;
    localparam int NC  = 2;
    // Short frame so the line-counter wrap is reached in a few thousand cycles.
    localparam int LD  = 24;
    localparam int WORDS_PER_LINE = BL * BN * NC;

    logic memclk = 1'b0;
    logic mem_rst, start, vs_clr, frame_sel, arb_idle, done, busy;

    rd_line_dma_if #(.DWIDTH(DW)) bus ();

    rd_line_dma #(
        .DWIDTH     (DW),
        .LINE_DEPTH (LD)
    ) dut (
        .memclk    (memclk),
        .mem_rst   (mem_rst),
        .start     (start),
        .vs_clr    (vs_clr),
        .frame_sel (frame_sel),
        .arb_idle  (arb_idle),
        .done      (done),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 memclk = ~memclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mcb_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [29:0]   exp_addr_q[$];
    logic [29:0]   cmd_log[$];
    int total_words = 0;
    int total_dones = 0;
    int full_mode   = 0;

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] exp_addr(input logic f, input int line, input int c, input int b);
        return 30'((f ? 4194304 : 0) + line * 4096 + c * 1440 + b * BL * (DW / 8));
    endfunction

    // MCB + FIFO model: samples at negedge, updates its outputs just after posedge.
    initial begin : model
        logic s_cmd, s_rd, s_wr, s_done, s_rst, burst_open;
        logic [29:0] s_addr;
        logic [5:0] s_bl;
        logic [2:0] s_instr;
        logic [DW-1:0] s_wdata, word;
        int burst_words, cyc, tag;
        burst_open = 1'b0; burst_words = 0; cyc = 0; tag = 1;
        bus.mcb_rd_empty = 1'b1;
        bus.mcb_rd_count = 7'd0;
        bus.mcb_rd_data  = '0;
        bus.fifo_full    = 1'b0;
        forever begin
            @(negedge memclk);
            s_cmd = bus.mcb_cmd_en;  s_addr = bus.mcb_cmd_byte_addr;
            s_bl = bus.mcb_cmd_bl;   s_instr = bus.mcb_cmd_instr;
            s_rd = bus.mcb_rd_en;    s_wr = bus.fifo_wr_en;
            s_wdata = bus.fifo_wr_data; s_done = done; s_rst = mem_rst;
            cmp("rd_en_eq_wr_en", DW'(s_rd), DW'(s_wr));
            if (s_cmd) begin
                cmd_log.push_back(s_addr);
                if (burst_open) cmp("burst_words", DW'(burst_words), DW'(BL));
                burst_open = 1'b1;
                burst_words = 0;
                cmp("cmd_instr", DW'(s_instr), DW'(3'b001));
                cmp("cmd_bl", DW'(s_bl), DW'(BL - 1));
                if (exp_addr_q.size() == 0) cmp("unexpected_cmd", DW'(1), DW'(0));
                else cmp("cmd_addr", DW'(s_addr), DW'(exp_addr_q.pop_front()));
            end
            if (s_wr) begin
                total_words++;
                burst_words++;
                if (exp_data_q.size() == 0) cmp("unexpected_wr", DW'(1), DW'(0));
                else cmp("wr_data", s_wdata, exp_data_q.pop_front());
            end
            if (s_done) begin
                total_dones++;
                cmp("last_burst_words", DW'(burst_words), DW'(BL));
                burst_open = 1'b0;
            end
            @(posedge memclk);
            #1;
            if (s_rst) begin
                mcb_q.delete(); exp_data_q.delete(); exp_addr_q.delete();
                burst_open = 1'b0;
            end else begin
                if (s_rd) void'(mcb_q.pop_front());
                if (s_cmd) begin
                    for (int i = 0; i < BL; i++) begin
                        word = {4{32'(tag)}};
                        tag++;
                        mcb_q.push_back(word);
                        exp_data_q.push_back(word);
                    end
                end
            end
            bus.mcb_rd_empty = (mcb_q.size() == 0);
            bus.mcb_rd_count = (mcb_q.size() > 127) ? 7'd127 : 7'(mcb_q.size());
            bus.mcb_rd_data  = (mcb_q.size() != 0) ? mcb_q[0] : '0;
            cyc++;
            bus.fifo_full = (full_mode == 1) && ((cyc % 3) == 2);
        end
    end

    task automatic run_line(input logic fsel, input int line, input int full,
                            input logic [29:0] exp_first, input int vs_at,
                            input logic poke, input string name);
        int w0, d0, c0;
        logic got;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < BN; b++)
                exp_addr_q.push_back(exp_addr(fsel, line, c, b));
        w0 = total_words; d0 = total_dones; c0 = cmd_log.size();
        full_mode = full;
        @(negedge memclk); frame_sel = fsel; start = 1'b1;
        @(negedge memclk); start = 1'b0; frame_sel = ~fsel;
        got = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge memclk);
            vs_clr = (k == vs_at);
            if (done) begin got = 1'b1; break; end
        end
        vs_clr = 1'b0;
        if (!got) cmp({name, "_done_timeout"}, DW'(0), DW'(1));
        if (poke) start = 1'b1;
        @(negedge memclk); start = 1'b0;
        @(negedge memclk);
        if (poke) cmp({name, "_start_on_done_ignored"}, DW'(busy), DW'(0));
        cmp({name, "_words"}, DW'(total_words - w0), DW'(WORDS_PER_LINE));
        cmp({name, "_dones"}, DW'(total_dones - d0), DW'(1));
        cmp({name, "_cmds"}, DW'(cmd_log.size() - c0), DW'(NC * BN));
        if (cmd_log.size() > c0) cmp({name, "_first_addr"}, DW'(cmd_log[c0]), DW'(exp_first));
        cmp({name, "_addr_q_left"}, DW'(exp_addr_q.size()), DW'(0));
        full_mode = 0;
        frame_sel = 1'b0;
    endtask

    typedef struct {
        logic        fsel;
        int          line;
        int          full;
        logic [29:0] first;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int c0;
        logic got;
        vecs[0] = '{1'b0, 0, 0, 30'd0};
        vecs[1] = '{1'b0, 1, 1, 30'd4096};
        vecs[2] = '{1'b1, 2, 0, 30'd4202496};
        vecs[3] = '{1'b0, 3, 1, 30'd12288};
        vecs[4] = '{1'b0, 4, 0, 30'd16384};
        vecs[5] = '{1'b1, 5, 1, 30'd4214784};

        mem_rst = 1'b1; start = 1'b0; vs_clr = 1'b0; frame_sel = 1'b0;
`ifdef RD_LINE_DMA_ARB_EN
        arb_idle = 1'b1;
`else
        arb_idle = 1'b0;
`endif
        bus.mcb_cmd_full = 1'b0;
        repeat (3) @(negedge memclk);
        cmp("rst_busy", DW'(busy), DW'(0));
        cmp("rst_done", DW'(done), DW'(0));
        cmp("rst_cmd_en", DW'(bus.mcb_cmd_en), DW'(0));
        cmp("rst_wr_en", DW'(bus.fifo_wr_en), DW'(0));
        cmp("rst_addr", DW'(bus.mcb_cmd_byte_addr), DW'(0));
        mem_rst = 1'b0;
        repeat (2) @(negedge memclk);

        for (int i = 0; i < 6; i++)
            run_line(vecs[i].fsel, vecs[i].line, vecs[i].full, vecs[i].first, -1, 1'b0, "tbl");

        // Line 6: command FIFO full for 20 cycles, then reset while draining.
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < BN; b++)
                exp_addr_q.push_back(exp_addr(1'b0, 6, c, b));
        c0 = cmd_log.size();
        bus.mcb_cmd_full = 1'b1;
        @(negedge memclk); start = 1'b1;
        @(negedge memclk); start = 1'b0;
        repeat (20) @(negedge memclk);
        cmp("no_cmd_while_full", DW'(cmd_log.size() - c0), DW'(0));
        bus.mcb_cmd_full = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge memclk);
            if (bus.fifo_wr_en) begin got = 1'b1; break; end
        end
        if (!got) cmp("data_start_timeout", DW'(0), DW'(1));
        repeat (10) @(negedge memclk);
        mem_rst = 1'b1;
        @(negedge memclk);
        mem_rst = 1'b0;
        cmp("midrst_busy", DW'(busy), DW'(0));
        cmp("midrst_done", DW'(done), DW'(0));
        cmp("midrst_cmd_en", DW'(bus.mcb_cmd_en), DW'(0));
        cmp("midrst_rd_en", DW'(bus.mcb_rd_en), DW'(0));
        cmp("midrst_wr_en", DW'(bus.fifo_wr_en), DW'(0));
        cmp("midrst_addr", DW'(bus.mcb_cmd_byte_addr), DW'(0));
        if (cmd_log.size() > c0) cmp("line6_first_addr", DW'(cmd_log[c0]), DW'(30'd24576));
        else cmp("line6_no_cmd", DW'(0), DW'(1));
        repeat (3) @(negedge memclk);

        // Reset returned the line counter to 0; vsync during line 10.
        for (int l = 0; l < 10; l++)
            run_line(1'b0, l, 0, exp_addr(1'b0, l, 0, 0), -1, 1'b0, "run");
        run_line(1'b0, 10, 0, 30'd40960, 60, 1'b0, "vs_line10");
        run_line(1'b0, 0, 0, 30'd0, -1, 1'b0, "after_vs");

        // Walk to the last line and wrap.
        for (int l = 1; l < LD; l++)
            run_line(1'b0, l, (l % 5 == 0) ? 1 : 0, exp_addr(1'b0, l, 0, 0), -1, 1'b0, "walk");
        run_line(1'b0, 0, 0, 30'd0, -1, 1'b1, "wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_line_dma.md
RD_LINE_DMA -- requirements
Module: rd_line_dma

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 128, MCB read data width in bits (multiple of 8).
REQ-002 The module SHALL have parameter BRST_LEN, default 45, words per MCB read burst (1..64).
REQ-003 The module SHALL have parameter BRST_NUM, default 2, bursts per channel per line (1..255).
REQ-004 The module SHALL have parameter NCH, default 2, channels (eyes/tiles) per line (1..4).
REQ-005 The module SHALL have parameter CH_STRIDE_BYTE, default 1440, byte offset between channels.
REQ-006 The module SHALL have parameters HSTART_BYTE (default 0), VSTART (default 0) and LINE_DEPTH (default 900), giving the first byte, first line and line count.
REQ-007 The module SHALL have parameters LINE_STRIDE_BYTE (default 4096) and FRAME_OFFSET_BYTE (default 4194304), giving the line and frame-buffer byte offsets.
REQ-008 The module SHALL have parameter RD_THRESH, default 8, the minimum mcb_rd_count before draining starts.
REQ-009 memclk  in  1  sole clock; reset is synchronous and active-high.
REQ-010 mem_rst  in  1  synchronous active-high reset.
REQ-011 start  in  1  line-fetch request, sampled in IDLE only.
REQ-012 vs_clr  in  1  pre-synchronised vertical-sync pulse that reloads the line counter.
REQ-013 frame_sel  in  1  selects the frame buffer; latched at start.
REQ-014 arb_idle  in  1  external arbiter grant (see Configuration).
REQ-015 done  out  1  one-cycle pulse when a line completes.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 mcb_cmd_en, mcb_cmd_instr[2:0], mcb_cmd_bl[5:0], mcb_cmd_byte_addr[29:0]  out  MCB command port.
REQ-018 mcb_cmd_full  in  1  MCB command FIFO full.
REQ-019 mcb_rd_en  out  1  MCB read strobe; mcb_rd_data[DWIDTH-1:0], mcb_rd_empty and mcb_rd_count[6:0] are inputs.
REQ-020 fifo_wr_en  out  1  and fifo_wr_data[DWIDTH-1:0]  out  downstream write port; fifo_full  in  1  is its backpressure.

Function
REQ-021 The module SHALL implement states IDLE, ISSUE, CMD, DATA and NEXT.
- IDLE->ISSUE on start; latches frame_sel; clears burst index b and channel index c.
REQ-022 In ISSUE, when mcb_cmd_full=0 (and the arbiter is granted), the module SHALL pulse mcb_cmd_en for 1 cycle and go to CMD.
- mcb_cmd_instr = 3'b001 (read); mcb_cmd_bl = BRST_LEN-1.
REQ-023 The command address SHALL be frame*FRAME_OFFSET_BYTE + line*LINE_STRIDE_BYTE + HSTART_BYTE + c*CH_STRIDE_BYTE + b*BRST_LEN*(DWIDTH/8), truncated to 30 bits.
REQ-024 CMD->DATA SHALL occur when mcb_rd_empty=0 and mcb_rd_count >= RD_THRESH.
REQ-025 In DATA, mcb_rd_en = fifo_wr_en = ~mcb_rd_empty & ~fifo_full (combinational), and fifo_wr_data = mcb_rd_data.
REQ-026 DATA SHALL count accepted words; after word BRST_LEN it goes to NEXT, and no word SHALL be lost or duplicated under any backpressure.
REQ-027 NEXT SHALL advance b, then c.
- Not the last burst: go to ISSUE.
- Last burst (b=BRST_NUM-1, c=NCH-1): pulse done, advance line, go to IDLE.
REQ-028 The line counter SHALL increment per completed line and wrap from VSTART+LINE_DEPTH-1 to VSTART.
REQ-029 vs_clr SHALL load line=VSTART immediately in IDLE.
- If vs_clr arrives while busy, it is held pending and applied at line completion, in place of the increment.
REQ-030 A start that coincides with a done pulse SHALL be ignored; start is only honoured in IDLE.

Reset
REQ-031 On mem_rst, the module SHALL go to IDLE with line=VSTART, b=c=0 and the pending vs_clr flag cleared.
- done, busy, mcb_cmd_en, mcb_rd_en and fifo_wr_en = 0; address = 0.
REQ-032 mem_rst mid-burst SHALL abort without draining the MCB; the MCB and FIFO are reset by their owners.

Configuration
REQ-033 With RD_LINE_DMA_ARB_EN defined, ISSUE SHALL additionally require arb_idle=1.
REQ-034 Without RD_LINE_DMA_ARB_EN, arb_idle SHALL be ignored, remaining as an unused port.

Structure
REQ-035 Package rd_line_dma_pkg SHALL hold the state encoding and the MCB instruction constants (READ=3'b001, WRITE=3'b000).
REQ-036 Address generation SHALL be a single sub-module, rd_line_addr_gen, that is combinational from (frame, line, c, b).

Verification
REQ-037 Defaults, frame_sel=0, line 0 -> addresses 0, 720, 1440 and 2160, each with bl=44, and one done pulse after 180 words.
REQ-038 frame_sel=1, line 5 -> first address = 4194304 + 5*4096 = 4214784.
REQ-039 fifo_full toggled every 3rd cycle in DATA -> exactly 45 fifo_wr_en per burst, and mcb_rd_en always equals fifo_wr_en.
REQ-040 900 lines run back to back -> line wraps 899->0, and the 901st first address is 0.
REQ-041 vs_clr during line 10 -> the next line fetches line 0, not line 11.
REQ-042 mcb_cmd_full held for 20 cycles, then mem_rst asserted in DATA -> no cmd_en while full; next cycle all outputs 0 and state = IDLE.
